// File: rtl/padding_window_scan_pkg.sv
// Shared geometry, bus types and FSM encoding for the padded-row window scanner.
// Stride selection (WIN_STRIDE2_EN) lives in padding_window_scan.sv.
package padding_pkg;

    localparam int IMG_W = 416;
    localparam int PIX_W = 8;
    localparam int PAD_W = IMG_W + 2;
    localparam int K     = 3;

    localparam int ROW_W = PAD_W * PIX_W;
    localparam int WIN_W = K * K * PIX_W;
    localparam int COL_W = 9;

    // Packed so that pixel j lands at bits [PIX_W*j +: PIX_W], column 0 at the LSBs.
    typedef logic [PAD_W-1:0][PIX_W-1:0] row_t;
    typedef logic [K*K-1:0][PIX_W-1:0]   win_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/padding_window_scan_if.sv
// Row-set input and 3x3x3 window output handshake bundle for padding_window_scan.
// slave = the scanner, master = the upstream/downstream environment.
interface padding_window_scan_if;
    import padding_pkg::*;

    logic             row_valid;
    logic             row_ready;
    row_t             R_row0, R_row1, R_row2;
    row_t             G_row0, G_row1, G_row2;
    row_t             B_row0, B_row1, B_row2;

    win_t             win_R, win_G, win_B;
    logic             win_valid;
    logic             win_ready;
    logic [COL_W-1:0] win_col;
    logic             win_last;

    modport slave (
        input  row_valid,
        input  R_row0, R_row1, R_row2,
        input  G_row0, G_row1, G_row2,
        input  B_row0, B_row1, B_row2,
        input  win_ready,
        output row_ready,
        output win_R, win_G, win_B,
        output win_valid, win_col, win_last
    );

    modport master (
        output row_valid,
        output R_row0, R_row1, R_row2,
        output G_row0, G_row1, G_row2,
        output B_row0, B_row1, B_row2,
        output win_ready,
        input  row_ready,
        input  win_R, win_G, win_B,
        input  win_valid, win_col, win_last
    );

endinterface

// File: rtl/padding_window_scan_window_extract.sv
// Per-channel combinational selector: three padded rows -> 3x3 window at column col_i.
// Element (r, c) of the window is row r, padded column col_i + c.
module window_extract
    import padding_pkg::*;
(
    input  row_t             row0_i,
    input  row_t             row1_i,
    input  row_t             row2_i,
    input  logic [COL_W-1:0] col_i,
    output win_t             win_o
);

    always_comb begin
        win_o = '0;
        for (int c = 0; c < K; c++) begin
            win_o[c]       = row0_i[col_i + COL_W'(c)];
            win_o[K + c]   = row1_i[col_i + COL_W'(c)];
            win_o[2*K + c] = row2_i[col_i + COL_W'(c)];
        end
    end

endmodule

// File: rtl/padding_window_scan.sv
// Latches one R/G/B padded row set and sweeps it into 3x3x3 windows, one per handshake.
// Define WIN_STRIDE2_EN to step the column by 2 (IMG_W/2 windows per row set).
//
// state | meaning
// IDLE  | waiting for a row set; row_ready=1, win_valid=0
// SCAN  | presenting the window at col; advance on win_ready
module padding_window_scan
    import padding_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    padding_window_scan_if.slave  bus
);

`ifdef WIN_STRIDE2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - STEP);
    localparam logic [COL_W-1:0] COL_STEP = COL_W'(STEP);

    state_t           state_q;
    logic [COL_W-1:0] col_q, col_d;
    logic             row_ready_q;
    logic             win_valid_q;
    logic             win_last_q;
    logic             capture;

    row_t r_q [K];
    row_t g_q [K];
    row_t b_q [K];

    assign capture = (state_q == IDLE) && bus.row_valid;
    assign col_d   = col_q + COL_STEP;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_ready_q <= 1'b1;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.row_valid) begin
                        state_q     <= SCAN;
                        col_q       <= '0;
                        row_ready_q <= 1'b0;
                        win_valid_q <= 1'b1;
                        win_last_q  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (bus.win_ready) begin
                        if (col_q == LAST_COL) begin
                            state_q     <= IDLE;
                            col_q       <= '0;
                            row_ready_q <= 1'b1;
                            win_valid_q <= 1'b0;
                            win_last_q  <= 1'b0;
                        end else begin
                            col_q      <= col_d;
                            win_last_q <= (col_d == LAST_COL);
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    col_q       <= '0;
                    row_ready_q <= 1'b1;
                    win_valid_q <= 1'b0;
                    win_last_q  <= 1'b0;
                end
            endcase
        end
    end

    // Rows are only written on acceptance, so bus changes during SCAN never reach the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < K; i++) begin
                r_q[i] <= '0;
                g_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else if (capture) begin
            r_q[0] <= bus.R_row0;
            r_q[1] <= bus.R_row1;
            r_q[2] <= bus.R_row2;
            g_q[0] <= bus.G_row0;
            g_q[1] <= bus.G_row1;
            g_q[2] <= bus.G_row2;
            b_q[0] <= bus.B_row0;
            b_q[1] <= bus.B_row1;
            b_q[2] <= bus.B_row2;
        end
    end

    window_extract u_extract_r (
        .row0_i (r_q[0]),
        .row1_i (r_q[1]),
        .row2_i (r_q[2]),
        .col_i  (col_q),
        .win_o  (bus.win_R)
    );

    window_extract u_extract_g (
        .row0_i (g_q[0]),
        .row1_i (g_q[1]),
        .row2_i (g_q[2]),
        .col_i  (col_q),
        .win_o  (bus.win_G)
    );

    window_extract u_extract_b (
        .row0_i (b_q[0]),
        .row1_i (b_q[1]),
        .row2_i (b_q[2]),
        .col_i  (col_q),
        .win_o  (bus.win_B)
    );

    assign bus.row_ready = row_ready_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_last  = win_last_q;
    assign bus.win_col   = col_q;

endmodule

// File: tb/tb_padding_window_scan.sv
// Scoreboard bench for padding_window_scan: row sets push their expected windows,
// a negedge monitor pops and compares on every window handshake.
module tb_padding_window_scan;
    import padding_pkg::*;

`ifdef WIN_STRIDE2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int NWIN = IMG_W / STEP;

    typedef struct {
        logic [COL_W-1:0] col;
        win_t             r;
        win_t             g;
        win_t             b;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    padding_window_scan_if bus();

    padding_window_scan dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          win_count = 0;
    byte unsigned pix[3][3][PAD_W];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    function automatic row_t pack_row(input int ch, input int r);
        row_t v;
        for (int j = 0; j < PAD_W; j++) v[j] = pix[ch][r][j];
        return v;
    endfunction

    function automatic row_t rand_row();
        row_t v;
        for (int j = 0; j < PAD_W; j++) v[j] = 8'($urandom);
        return v;
    endfunction

    function automatic win_t model_win(input int ch, input int col);
        win_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[3*r + c] = pix[ch][r][col + c];
        return w;
    endfunction

    task automatic fill_pattern();
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 3; r++)
                for (int j = 0; j < PAD_W; j++)
                    pix[ch][r][j] = 8'(j + r + 16*ch);
    endtask

    task automatic fill_random();
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 3; r++)
                for (int j = 0; j < PAD_W; j++)
                    pix[ch][r][j] = 8'($urandom);
    endtask

    task automatic drive_rows();
        bus.R_row0 = pack_row(0, 0); bus.R_row1 = pack_row(0, 1); bus.R_row2 = pack_row(0, 2);
        bus.G_row0 = pack_row(1, 0); bus.G_row1 = pack_row(1, 1); bus.G_row2 = pack_row(1, 2);
        bus.B_row0 = pack_row(2, 0); bus.B_row1 = pack_row(2, 1); bus.B_row2 = pack_row(2, 2);
    endtask

    task automatic drive_garbage();
        bus.R_row0 = rand_row(); bus.R_row1 = rand_row(); bus.R_row2 = rand_row();
        bus.G_row0 = rand_row(); bus.G_row1 = rand_row(); bus.G_row2 = rand_row();
        bus.B_row0 = rand_row(); bus.B_row1 = rand_row(); bus.B_row2 = rand_row();
    endtask

    task automatic push_expected();
        exp_t e;
        for (int k = 0; k < NWIN; k++) begin
            e.col  = COL_W'(k * STEP);
            e.r    = model_win(0, k * STEP);
            e.g    = model_win(1, k * STEP);
            e.b    = model_win(2, k * STEP);
            e.last = (k == NWIN - 1);
            sb.push_back(e);
        end
    endtask

    // Monitor: compare on handshake; while stalled the window must still equal the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.win_valid) begin
            check("row_ready_during_scan", 128'(bus.row_ready), 128'(0));
            if (sb.size() == 0) begin
                fail_now("unexpected_window", $sformatf("col %0d with empty scoreboard", bus.win_col));
            end else begin
                e = sb[0];
                check(bus.win_ready ? "win_col" : "stall_col", 128'(bus.win_col), 128'(e.col));
                check(bus.win_ready ? "win_R" : "stall_R", 128'(bus.win_R), 128'(e.r));
                check(bus.win_ready ? "win_G" : "stall_G", 128'(bus.win_G), 128'(e.g));
                check(bus.win_ready ? "win_B" : "stall_B", 128'(bus.win_B), 128'(e.b));
                check(bus.win_ready ? "win_last" : "stall_last", 128'(bus.win_last), 128'(e.last));
                if (bus.win_ready) begin
                    void'(sb.pop_front());
                    win_count++;
                end
            end
        end
    end

    task automatic send_rowset();
        int t = 0;
        drive_rows();
        bus.row_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.row_ready && t < 50);
        if (!bus.row_ready) begin
            fail_now("accept_timeout", "row_ready never asserted");
            bus.row_valid = 1'b0;
            return;
        end
        win_count = 0;
        @(posedge clk);
        push_expected();
        #1 bus.row_valid = 1'b0;
    endtask

    // mode 0: ready held; 1: 5-cycle stall at col 10; 2: random ready + bus noise; 3: reset at col 100
    task automatic run_scan(input int mode);
        int cyc = 0;
        int stall = 0;
        while (sb.size() > 0 && cyc < 4000) begin
            case (mode)
                1: begin
                    bus.win_ready = !(bus.win_col == 10 && stall < 5);
                    if (!bus.win_ready) stall++;
                end
                2: bus.win_ready = ($urandom_range(0, 3) != 0);
                3: begin
                    bus.win_ready = 1'b1;
                    if (bus.win_col == 100) begin
                        reset = 1'b1;
                        bus.win_ready = 1'b0;
                        @(posedge clk);
                        #1 reset = 1'b0;
                        sb.delete();
                        check("rst_mid_valid", 128'(bus.win_valid), 128'(0));
                        check("rst_mid_ready", 128'(bus.row_ready), 128'(1));
                        check("rst_mid_winR", 128'(bus.win_R), 128'(0));
                        bus.win_ready = 1'b1;
                        return;
                    end
                end
                default: bus.win_ready = 1'b1;
            endcase
            if (mode >= 2 && sb.size() > 20) begin
                bus.row_valid = 1'($urandom);
                drive_garbage();
            end else begin
                bus.row_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.row_valid = 1'b0;
        bus.win_ready = 1'b1;
        if (sb.size() > 0) begin
            fail_now("scan_timeout", $sformatf("%0d windows still outstanding", sb.size()));
            sb.delete();
        end else begin
            check("window_count", 128'(win_count), 128'(NWIN));
            check("post_idle_ready", 128'(bus.row_ready), 128'(1));
            check("post_idle_valid", 128'(bus.win_valid), 128'(0));
            check("post_idle_last", 128'(bus.win_last), 128'(0));
        end
        if (mode == 1) check("stall_cycles", 128'(stall), 128'(5));
    endtask

    initial begin
        win_t col0_r;
        col0_r = 72'h04_03_02_03_02_01_02_01_00;

        reset = 1'b1;
        bus.row_valid = 1'b1;
        bus.win_ready = 1'b1;
        drive_garbage();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_row_ready", 128'(bus.row_ready), 128'(1));
        check("rst_win_valid", 128'(bus.win_valid), 128'(0));
        check("rst_win_col", 128'(bus.win_col), 128'(0));
        check("rst_win_last", 128'(bus.win_last), 128'(0));
        check("rst_win_R", 128'(bus.win_R), 128'(0));
        check("rst_win_B", 128'(bus.win_B), 128'(0));
        reset = 1'b0;
        bus.row_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_no_capture", 128'(bus.win_valid), 128'(0));

        fill_pattern();
        send_rowset();
        check("col0_valid", 128'(bus.win_valid), 128'(1));
        check("col0_col", 128'(bus.win_col), 128'(0));
        check("col0_winR", 128'(bus.win_R), 128'(col0_r));
        run_scan(0);

        fill_pattern();
        send_rowset();
        run_scan(1);

        fill_random();
        send_rowset();
        run_scan(2);

        fill_random();
        send_rowset();
        run_scan(3);

        fill_random();
        send_rowset();
        check("restart_col", 128'(bus.win_col), 128'(0));
        run_scan(0);

        fill_random();
        send_rowset();
        run_scan(2);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
